// File: rtl/morse_sequencer_if.sv
// Start/select request and Morse status bundle for morse_sequencer.
interface morse_sequencer_if;
    logic       m_start;
    logic [5:0] m_select;
    logic       m_out;
    logic       m_busy;
    logic       m_done;
    logic       m_err;

    // Requester side: drives start/select, observes LED and status.
    modport master (
        output m_start,
        output m_select,
        input  m_out,
        input  m_busy,
        input  m_done,
        input  m_err
    );

    // Sequencer side.
    modport slave (
        input  m_start,
        input  m_select,
        output m_out,
        output m_busy,
        output m_done,
        output m_err
    );
endinterface

// File: rtl/morse_sequencer.sv
// Morse code generator for A-Z and 0-9 with unit-exact mark/gap timing.
// Optional macro MORSE_REPEAT_EN: while m_start stays high the captured
// letter repeats with a 7-unit word gap between letters.
module morse_sequencer #(
    parameter int unsigned UNIT_CYCLES = 25000000,
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned LETTER_GAP  = 3
) (
    input  logic             m_clock,
    input  logic             m_clear,
    morse_sequencer_if.slave bus
);
    localparam int unsigned UNITS_W    = 8;
    localparam int unsigned WORD_UNITS = 4;
    localparam logic [CNT_W-1:0] UNIT_LOAD = CNT_W'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_GAP,
        S_TAIL,
        S_WORD
    } state_t;

    // Table entry: {len[2:0], code[4:0]}; code right-aligned, first symbol at bit len-1, 1 = dash.
    function automatic logic [7:0] morse_lut(input logic [5:0] sel);
        logic [7:0] ent;
        ent = 8'd0;
        case (sel)
            6'd0:  ent = {3'd2, 5'b00001}; // A .-
            6'd1:  ent = {3'd4, 5'b01000}; // B -...
            6'd2:  ent = {3'd4, 5'b01010}; // C -.-.
            6'd3:  ent = {3'd3, 5'b00100}; // D -..
            6'd4:  ent = {3'd1, 5'b00000}; // E .
            6'd5:  ent = {3'd4, 5'b00010}; // F ..-.
            6'd6:  ent = {3'd3, 5'b00110}; // G --.
            6'd7:  ent = {3'd4, 5'b00000}; // H ....
            6'd8:  ent = {3'd2, 5'b00000}; // I ..
            6'd9:  ent = {3'd4, 5'b00111}; // J .---
            6'd10: ent = {3'd3, 5'b00101}; // K -.-
            6'd11: ent = {3'd4, 5'b00100}; // L .-..
            6'd12: ent = {3'd2, 5'b00011}; // M --
            6'd13: ent = {3'd2, 5'b00010}; // N -.
            6'd14: ent = {3'd3, 5'b00111}; // O ---
            6'd15: ent = {3'd4, 5'b00110}; // P .--.
            6'd16: ent = {3'd4, 5'b01101}; // Q --.-
            6'd17: ent = {3'd3, 5'b00010}; // R .-.
            6'd18: ent = {3'd3, 5'b00000}; // S ...
            6'd19: ent = {3'd1, 5'b00001}; // T -
            6'd20: ent = {3'd3, 5'b00001}; // U ..-
            6'd21: ent = {3'd4, 5'b00001}; // V ...-
            6'd22: ent = {3'd3, 5'b00011}; // W .--
            6'd23: ent = {3'd4, 5'b01001}; // X -..-
            6'd24: ent = {3'd4, 5'b01011}; // Y -.--
            6'd25: ent = {3'd4, 5'b01100}; // Z --..
            6'd26: ent = {3'd5, 5'b11111}; // 0
            6'd27: ent = {3'd5, 5'b01111}; // 1
            6'd28: ent = {3'd5, 5'b00111}; // 2
            6'd29: ent = {3'd5, 5'b00011}; // 3
            6'd30: ent = {3'd5, 5'b00001}; // 4
            6'd31: ent = {3'd5, 5'b00000}; // 5
            6'd32: ent = {3'd5, 5'b10000}; // 6
            6'd33: ent = {3'd5, 5'b11000}; // 7
            6'd34: ent = {3'd5, 5'b11100}; // 8
            6'd35: ent = {3'd5, 5'b11110}; // 9
            default: ent = 8'd0;
        endcase
        return ent;
    endfunction

    state_t             state_q;
    logic               start_q;
    logic [5:0]         sel_q;
    logic [2:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [UNITS_W-1:0] units_q;
    logic               out_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [7:0]         lut_cur;
    logic [7:0]         lut_new;
    logic [2:0]         cur_len;
    logic [2:0]         new_len;
    logic [4:0]         cur_code;
    logic [2:0]         bit_sel;
    logic               cur_dash;
    logic [UNITS_W-1:0] target_units;
    logic               tick;
    logic               unit_last;
    logic               start_edge;
    logic               sel_valid;

    // Symbol lookup, interval length for the current state and unit/edge decode.
    always_comb begin
        lut_cur      = morse_lut(sel_q);
        lut_new      = morse_lut(bus.m_select);
        cur_len      = 3'(lut_cur >> 5);
        new_len      = 3'(lut_new >> 5);
        cur_code     = 5'(lut_cur);
        bit_sel      = idx_q - 3'd1;
        cur_dash     = |(cur_code & (5'b00001 << bit_sel));
        target_units = UNITS_W'(1);
        case (state_q)
            S_MARK:  target_units = cur_dash ? UNITS_W'(3) : UNITS_W'(1);
            S_GAP:   target_units = UNITS_W'(1);
            S_TAIL:  target_units = UNITS_W'(LETTER_GAP);
            S_WORD:  target_units = UNITS_W'(WORD_UNITS);
            default: target_units = UNITS_W'(1);
        endcase
        tick       = (cnt_q == '0);
        unit_last  = (units_q == target_units - UNITS_W'(1));
        start_edge = bus.m_start & ~start_q;
        sel_valid  = (bus.m_select < 6'd36);
    end

    // Sequencer FSM with unit timer and registered outputs.
    always_ff @(posedge m_clock or negedge m_clear) begin
        if (!m_clear) begin
            state_q <= S_IDLE;
            start_q <= 1'b1;
            sel_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            units_q <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= bus.m_start;
            done_q  <= 1'b0;
            err_q   <= 1'b0;

            if (state_q != S_IDLE) begin
                if (tick) begin
                    cnt_q   <= UNIT_LOAD;
                    units_q <= unit_last ? '0 : units_q + UNITS_W'(1);
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        if (sel_valid) begin
                            sel_q   <= bus.m_select;
                            idx_q   <= new_len;
                            cnt_q   <= UNIT_LOAD;
                            units_q <= '0;
                            out_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_MARK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    if (tick && unit_last) begin
                        idx_q   <= idx_q - 3'd1;
                        out_q   <= 1'b0;
                        state_q <= (idx_q == 3'd1) ? S_TAIL : S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick && unit_last) begin
                        out_q   <= 1'b1;
                        state_q <= S_MARK;
                    end
                end
                S_TAIL: begin
                    if (tick && unit_last) begin
                        done_q <= 1'b1;
`ifdef MORSE_REPEAT_EN
                        if (bus.m_start) begin
                            state_q <= S_WORD;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
`else
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                end
`ifdef MORSE_REPEAT_EN
                S_WORD: begin
                    if (tick && unit_last) begin
                        idx_q   <= cur_len;
                        out_q   <= 1'b1;
                        state_q <= S_MARK;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_out  = out_q;
    assign bus.m_busy = busy_q;
    assign bus.m_done = done_q;
    assign bus.m_err  = err_q;

endmodule
